// File: rtl/aquila_mem_arbiter.sv
// Shares one single-port memory-model port between the fetch and data channels.
// Define AQ_MEM_ARB_RR_EN for round-robin arbitration instead of data-first priority.
module aquila_mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              code_req_i,
   input  logic [XLEN-1:0]   code_addr_i,
   output logic [XLEN-1:0]   code_o,
   output logic              code_ready_o,
   input  logic              data_req_i,
   input  logic              data_rw_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_i,
   input  logic [XLEN/8-1:0] data_byte_enable_i,
   output logic [XLEN-1:0]   data_o,
   output logic              data_ready_o,
   output logic              mem_req_o,
   output logic              mem_rw_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic              mem_src_o,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              busy_o,
   output logic              err_o
);

   localparam int BW = XLEN / 8;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state;
   state_t            state_nx;
   logic              code_pend;
   logic              data_pend;
   logic [XLEN-1:0]   code_addr;
   logic              data_rw;
   logic [XLEN-1:0]   data_addr;
   logic [XLEN-1:0]   data_wdata;
   logic [BW-1:0]     data_be;
   logic              grant;
   logic              pick_data;
   logic              data_take;
`ifdef AQ_MEM_ARB_RR_EN
   logic              last_data;
`else
   logic [3:0]        starve;
`endif

   always_comb begin
      state_nx  = state;
      grant     = 1'b0;
      pick_data = 1'b0;
`ifdef AQ_MEM_ARB_RR_EN
      pick_data = data_pend && (!code_pend || !last_data);
`else
      pick_data = data_pend &&
                  (!code_pend || (starve < 4'(STARVE_LIMIT)));
`endif
      unique case (state)
         IDLE: begin
            if (code_pend || data_pend) begin
               grant    = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (mem_ready_i) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // A new data request is legal when the slot is empty or is being granted now.
   assign data_take = !data_pend || (grant && pick_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_pend    <= 1'b0;
         data_pend    <= 1'b0;
         code_addr    <= '0;
         data_rw      <= 1'b0;
         data_addr    <= '0;
         data_wdata   <= '0;
         data_be      <= '0;
         mem_req_o    <= 1'b0;
         mem_rw_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         mem_be_o     <= '0;
         mem_src_o    <= 1'b0;
         code_o       <= '0;
         data_o       <= '0;
         code_ready_o <= 1'b0;
         data_ready_o <= 1'b0;
         err_o        <= 1'b0;
`ifdef AQ_MEM_ARB_RR_EN
         last_data    <= 1'b0;
`else
         starve       <= '0;
`endif
      end else begin
         mem_req_o    <= grant;
         code_ready_o <= 1'b0;
         data_ready_o <= 1'b0;

         if (grant) begin
            mem_src_o <= pick_data;
`ifdef AQ_MEM_ARB_RR_EN
            last_data <= pick_data;
`endif
            if (pick_data) begin
               mem_rw_o    <= data_rw;
               mem_addr_o  <= data_addr;
               mem_wdata_o <= data_wdata;
               mem_be_o    <= data_be;
               data_pend   <= 1'b0;
`ifndef AQ_MEM_ARB_RR_EN
               if (code_pend && (starve < 4'(STARVE_LIMIT)))
                  starve <= starve + 4'd1;
`endif
            end else begin
               mem_rw_o    <= 1'b0;
               mem_addr_o  <= code_addr;
               mem_wdata_o <= '0;
               mem_be_o    <= '1;
               code_pend   <= 1'b0;
`ifndef AQ_MEM_ARB_RR_EN
               starve      <= '0;
`endif
            end
         end

         if (code_req_i) begin
            code_pend <= 1'b1;
            code_addr <= code_addr_i;
         end

         if (data_req_i) begin
            if (data_take) begin
               data_pend  <= 1'b1;
               data_rw    <= data_rw_i;
               data_addr  <= data_addr_i;
               data_wdata <= data_i;
               data_be    <= data_byte_enable_i;
            end else begin
               err_o <= 1'b1;
            end
         end

         if ((state == WAIT) && mem_ready_i) begin
            if (mem_src_o) begin
               data_ready_o <= 1'b1;
               if (!mem_rw_o) data_o <= mem_rdata_i;
            end else begin
               code_ready_o <= 1'b1;
               code_o       <= mem_rdata_i;
            end
         end
      end
   end

   assign busy_o = (state != IDLE) || code_pend || data_pend;

endmodule

// File: tb/tb_aquila_mem_arbiter.sv
// Scoreboard bench for aquila_mem_arbiter with a request-level reference model.
// Honors AQ_MEM_ARB_RR_EN to match the arbitration policy under test.
module tb_aquila_mem_arbiter;

   localparam int XLEN = 32;
   localparam int LIM  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        code_req_i = 1'b0;
   logic [31:0] code_addr_i = '0;
   logic [31:0] code_o;
   logic        code_ready_o;
   logic        data_req_i = 1'b0;
   logic        data_rw_i = 1'b0;
   logic [31:0] data_addr_i = '0;
   logic [31:0] data_i = '0;
   logic [3:0]  data_byte_enable_i = '0;
   logic [31:0] data_o;
   logic        data_ready_o;
   logic        mem_req_o;
   logic        mem_rw_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_src_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ready_i = 1'b0;
   logic        busy_o;
   logic        err_o;

   always #5 clk = ~clk;

   aquila_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .code_req_i(code_req_i), .code_addr_i(code_addr_i),
      .code_o(code_o), .code_ready_o(code_ready_o),
      .data_req_i(data_req_i), .data_rw_i(data_rw_i),
      .data_addr_i(data_addr_i), .data_i(data_i),
      .data_byte_enable_i(data_byte_enable_i),
      .data_o(data_o), .data_ready_o(data_ready_o),
      .mem_req_o(mem_req_o), .mem_rw_o(mem_rw_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_be_o(mem_be_o), .mem_src_o(mem_src_o),
      .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct {
      logic        src;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } grant_t;

   grant_t      gq[$];
   logic [31:0] cq[$];
   logic [31:0] dq[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mem_val(logic [31:0] a);
      if (a == 32'h100) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic fail(string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event expected=none", name);
   endtask

   // Reference model: request slots, one outstanding transaction, priority rule.
   bit          m_busy = 0;
   bit          m_cp = 0;
   bit          m_dp = 0;
   bit          m_err = 0;
   bit          m_last_data = 0;
   int          m_starve = 0;
   logic [31:0] m_caddr = '0;
   bit          m_drw = 0;
   logic [31:0] m_daddr = '0;
   logic [31:0] m_dw = '0;
   logic [3:0]  m_dbe = '0;
   logic [31:0] m_dout = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_cp = 0; m_dp = 0; m_err = 0;
         m_last_data = 0; m_starve = 0; m_dout = '0;
         gq.delete(); cq.delete(); dq.delete();
      end else begin : step
         bit     g;
         bit     gd;
         grant_t e;
         g = !m_busy && (m_cp || m_dp);
         if (m_busy && mem_ready_i) m_busy = 0;
         if (g) begin
`ifdef AQ_MEM_ARB_RR_EN
            gd = m_dp && (!m_cp || !m_last_data);
`else
            gd = m_dp && (!m_cp || m_starve < LIM);
`endif
            m_last_data = gd;
            m_busy = 1;
            if (gd) begin
               e = '{1'b1, m_drw, m_daddr, m_dw, m_dbe};
               if (!m_drw) m_dout = mem_val(m_daddr);
               dq.push_back(m_dout);
               if (m_cp && m_starve < LIM) m_starve++;
               m_dp = 0;
            end else begin
               e = '{1'b0, 1'b0, m_caddr, 32'h0, 4'hF};
               cq.push_back(mem_val(m_caddr));
               m_starve = 0;
               m_cp = 0;
            end
            gq.push_back(e);
         end
         if (code_req_i) begin
            m_cp = 1;
            m_caddr = code_addr_i;
         end
         if (data_req_i) begin
            if (m_dp) m_err = 1;
            else begin
               m_dp = 1; m_drw = data_rw_i; m_daddr = data_addr_i;
               m_dw = data_i; m_dbe = data_byte_enable_i;
            end
         end
      end
   end

   // Memory responder: answers each mem_req_o after 0..3 cycles (6 when slow).
   bit          r_out = 0;
   int          r_cnt = 0;
   logic [31:0] r_addr = '0;
   bit          slow = 0;
   bit          spur_en = 0;
   bit          force_spur = 0;

   always @(posedge clk) begin
      #3;
      mem_ready_i = 1'b0;
      if (!rst_n) r_out = 0;
      else begin
         if (mem_req_o) begin
            r_out = 1;
            r_cnt = slow ? 6 : int'($urandom_range(0, 3));
            r_addr = mem_addr_o;
         end
         if (r_out) begin
            if (r_cnt == 0) begin
               mem_ready_i = 1'b1;
               mem_rdata_i = mem_val(r_addr);
               r_out = 0;
            end else r_cnt--;
         end else if (force_spur || (spur_en && $urandom_range(0, 7) == 0)) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = $urandom;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a grant or response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req_o) begin
            if (gq.size() == 0) fail("grant_unexpected");
            else begin : cmpg
               grant_t e;
               e = gq.pop_front();
               chk("grant_src", mem_src_o, e.src);
               chk("grant_rw", mem_rw_o, e.rw);
               chk("grant_addr", mem_addr_o, e.addr);
               chk("grant_be", mem_be_o, e.be);
               if (e.src && e.rw) chk("grant_wdata", mem_wdata_o, e.wdata);
            end
         end
         if (code_ready_o) begin
            if (cq.size() == 0) fail("code_ready_unexpected");
            else chk("code_o", code_o, cq.pop_front());
         end
         if (data_ready_o) begin
            if (dq.size() == 0) fail("data_ready_unexpected");
            else chk("data_o", data_o, dq.pop_front());
         end
         chk("err_o", err_o, m_err);
         chk("busy_o", busy_o, m_busy || m_cp || m_dp);
      end
   end

   task automatic req(bit c, logic [31:0] ca, bit d, bit rw,
                      logic [31:0] da, logic [31:0] wd, logic [3:0] be);
      code_req_i = c; code_addr_i = ca;
      data_req_i = d; data_rw_i = rw; data_addr_i = da;
      data_i = wd; data_byte_enable_i = be;
      @(posedge clk); #2;
      code_req_i = 1'b0; data_req_i = 1'b0;
   endtask

   task automatic wait_idle(int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(busy_o == 1'b0 && gq.size() == 0 && cq.size() == 0 &&
                   dq.size() == 0 && !code_ready_o && !data_ready_o) && n < limit);
      if (n >= limit) fail("wait_idle_timeout");
   endtask

   task automatic wait_grant(bit src, int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(mem_req_o && mem_src_o == src) && n < limit);
      if (n >= limit) fail("wait_grant_timeout");
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_code_o"}, code_o, 0);
      chk({tag, "_code_ready"}, code_ready_o, 0);
      chk({tag, "_data_o"}, data_o, 0);
      chk({tag, "_data_ready"}, data_ready_o, 0);
      chk({tag, "_mem_req"}, mem_req_o, 0);
      chk({tag, "_mem_rw"}, mem_rw_o, 0);
      chk({tag, "_mem_addr"}, mem_addr_o, 0);
      chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
      chk({tag, "_mem_be"}, mem_be_o, 0);
      chk({tag, "_mem_src"}, mem_src_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   task automatic random_phase(int cycles);
      spur_en = 1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #2;
         code_req_i = ($urandom_range(0, 3) == 0);
         code_addr_i = {$urandom_range(0, 65535), 2'b00};
         data_req_i = ($urandom_range(0, 3) == 0);
         data_rw_i = $urandom_range(0, 1);
         data_addr_i = {$urandom_range(0, 65535), 2'b00};
         data_i = $urandom;
         data_byte_enable_i = 4'($urandom_range(1, 15));
      end
      @(posedge clk); #2;
      code_req_i = 1'b0; data_req_i = 1'b0;
      spur_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk); #2;
      rst_n = 1'b1;

      @(posedge clk); #2;
      req(1, 32'h100, 0, 0, 0, 0, 0);
      wait_idle(50);
      chk("fetch_0x13", code_o, 32'h13);

      @(posedge clk); #2;
      req(1, 32'h104, 1, 0, 32'h2000, 0, 4'hF);
      wait_idle(50);

      @(posedge clk); #2;
      req(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 4'h3);
      wait_idle(50);
      chk("write_keeps_data_o", data_o, mem_val(32'h2000));

      @(posedge clk); #2;
      req(1, 32'h300, 1, 0, 32'h3000, 0, 4'hF);
      for (int i = 1; i < 5; i++) begin
         wait_grant(1, 50);
         req(0, 0, 1, 0, 32'h3000 + 32'(4 * i), 0, 4'hF);
      end
      wait_idle(100);

      slow = 1;
      @(posedge clk); #2;
      req(1, 32'h400, 0, 0, 0, 0, 0);
      wait_grant(0, 50);
      @(posedge clk); #2;
      req(0, 0, 1, 0, 32'h4000, 0, 4'hF);
      req(0, 0, 1, 0, 32'h4004, 0, 4'hF);
      slow = 0;
      wait_idle(100);
      chk("err_sticky", err_o, 1);

      random_phase(400);
      wait_idle(200);

      slow = 1;
      @(posedge clk); #2;
      req(1, 32'h500, 0, 0, 0, 0, 0);
      wait_grant(0, 50);
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk); #2;
      rst_n = 1'b1;
      slow = 0;
      force_spur = 1;
      @(posedge clk); #2;
      force_spur = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("postrst");

      random_phase(200);
      wait_idle(200);
      chk("final_busy", busy_o, 0);
      chk("final_grants_left", gq.size(), 0);
      chk("final_code_left", cq.size(), 0);
      chk("final_data_left", dq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aquila_mem_arbiter.md
Name: aquila_mem_arbiter

Overview:
Arbitrates the core's instruction-fetch channel and data channel onto one shared memory-model port, one transaction in flight at a time. Sits between the Aquila core bus signals and the single-port memory model used by the fuzzing harness. Latches requests, grants by priority with starvation protection, and routes each response back to its originating channel with a one-cycle ready pulse.

Parameters:
XLEN, 32, address/data width
STARVE_LIMIT, 4, consecutive data grants allowed while code is pending before code is forced (range 1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
code_req_i  in  1  fetch request pulse
code_addr_i  in  XLEN  fetch address
code_o  out  XLEN  fetched instruction, valid with code_ready_o
code_ready_o  out  1  one-cycle fetch completion pulse
data_req_i  in  1  data request pulse
data_rw_i  in  1  0 read, 1 write
data_addr_i  in  XLEN  data address
data_i  in  XLEN  write data
data_byte_enable_i  in  XLEN/8  write byte enables
data_o  out  XLEN  read data, valid with data_ready_o
data_ready_o  out  1  one-cycle data completion pulse (reads and writes)
mem_req_o  out  1  one-cycle request pulse to memory model
mem_rw_o  out  1  0 read, 1 write
mem_addr_o  out  XLEN  address
mem_wdata_o  out  XLEN  write data
mem_be_o  out  XLEN/8  byte enables (all ones for code)
mem_src_o  out  1  0 code, 1 data
mem_rdata_i  in  XLEN  response data
mem_ready_i  in  1  response strobe
busy_o  out  1  state!=IDLE or any pending
err_o  out  1  sticky: data request dropped

Behaviour:
- Reset: all outputs 0, state IDLE, pending flags clear, starve counter 0, err_o 0. Reset mid-transaction drops the in-flight op; no ready pulse is emitted for it.
- Capture: req_i at edge E sets the channel pending flag and latches its fields. Code req while code pending overwrites the address. Data req while data pending is dropped and sets err_o (cleared only by reset). Pending clears on grant, so a req at the grant edge re-arms pending with the new fields.
- FSM IDLE: if any pending, grant at the next edge: register mem_* fields, mem_req_o=1 for exactly one cycle, go to WAIT. Otherwise stay.
- FSM WAIT: mem_ready_i is sampled in every WAIT cycle, including the mem_req_o cycle. On ready: register mem_rdata_i into code_o or data_o per mem_src_o and pulse the matching ready_o for one cycle next cycle. Go to IDLE. Writes also pulse data_ready_o; data_o holds its old value on writes. mem_ready_i in IDLE is ignored.
- Latency: req at cycle 0, mem_req_o at cycle 2, ready_o at the cycle after mem_ready_i. Minimum 3 cycles. Back-to-back grants are separated by at least one IDLE cycle.
- Arbitration: data beats code. The starve counter increments on each data grant while code is pending and saturates at STARVE_LIMIT. At STARVE_LIMIT with both pending, code wins. Any code grant resets the counter.
- code_o and data_o hold their values between responses.

Optional Feature:
AQ_MEM_ARB_RR_EN
- Defined: round-robin arbitration. A last-granted flag (reset to code) alternates winners under contention. Starve counter and STARVE_LIMIT are unused.
- Undefined: fixed priority with starvation limit, as above.

Test Plan:
- Code req at addr 0x100, mem_ready_i 2 cycles after mem_req_o with rdata 0x00000013 -> mem_src_o=0, mem_addr_o=0x100, code_o=0x13 with a one-cycle code_ready_o pulse; data_ready_o stays 0.
- Code and data reqs in the same cycle (data read 0x2000) -> data granted first, code second; responses routed to correct ports; busy_o low after both complete.
- Data write 0x2004, data_i=0xDEADBEEF, be=0x3 -> mem_rw_o=1, mem_wdata_o=0xDEADBEEF, mem_be_o=0x3, data_ready_o pulse, data_o unchanged.
- Code held pending while 5 data reqs issue back-to-back, STARVE_LIMIT=4 -> code granted after the 4th data grant. With AQ_MEM_ARB_RR_EN, grants alternate data/code instead.
- Second data req while the first is pending -> dropped, err_o=1 and sticky; only one data_ready_o pulse.
- rst_n asserted while in WAIT, then mem_ready_i pulsed after release -> no ready_o pulse, all outputs 0, state IDLE.
